loctag_sequencer: RTL and testbench

- Parametrised successor of the trig-driven backscatter tag controller.
- Sequences each probe packet through these phases: START, INFO, MOD, TAIL, WAIT_END.
- Phase durations are per-mode parameters, counted in microsecond ticks.
- Drives the modulation bit, the frequency-shift enable, the ADC start pulse and the captured RSS.
- Sits between the trigger detector and the RF switch driver; the adc7478 controller is external.

---
 rtl/loctag_pkg.sv | 35 +++
 rtl/loctag_us_tick.sv | 37 +++
 rtl/loctag_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_loctag_sequencer.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loctag_pkg.sv
// Shared definitions for the loctag probe-packet sequencer: state codes,
// mode codes, phase-duration width and the RSS reset fill value.
package loctag_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FORCE_FS = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_INFO     = 3'd3;
    localparam logic [2:0] ST_MOD      = 3'd4;
    localparam logic [2:0] ST_TAIL     = 3'd5;
    localparam logic [2:0] ST_WAIT_END = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        FORCE_FS = ST_FORCE_FS,
        START    = ST_START,
        INFO     = ST_INFO,
        MOD      = ST_MOD,
        TAIL     = ST_TAIL,
        WAIT_END = ST_WAIT_END
    } state_t;

    localparam logic [1:0] MODE_B = 2'b10;
    localparam logic [1:0] MODE_N = 2'b01;

    localparam int DUR_W = 11;

    localparam logic RSS_RESET_BIT = 1'b1;

    // A zero-length START/INFO/MOD would never see its exit tick, so clamp to one.
    function automatic logic [DUR_W-1:0] min_one(input int d);
        return (d == 0) ? DUR_W'(1) : DUR_W'(d);
    endfunction

endpackage

// File: rtl/loctag_us_tick.sv
// Microsecond tick generator: a clock divider plus a microsecond counter,
// both cleared whenever the sequencer enters a new state.
module loctag_us_tick #(
    parameter int CLK_PER_US = 50,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic             us_tick,
    output logic [CNT_W-1:0] count
);

    localparam int DIV_W = $clog2(CLK_PER_US);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_US - 1);

    logic [DIV_W-1:0] div;

    assign us_tick = (div == DIV_LAST);

    // Divider wraps every CLK_PER_US clocks; the counter advances once per wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div   <= '0;
            count <= '0;
        end else if (clear) begin
            div   <= '0;
            count <= '0;
        end else begin
            div <= us_tick ? '0 : div + 1'b1;
            if (us_tick) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/loctag_sequencer.sv
// Probe-packet sequencer for the backscatter localisation tag.
// Walks START, INFO, MOD, TAIL, WAIT_END with per-mode durations in microseconds,
// drives the modulation bit, frequency-shift enable, ADC start and latched RSS.
// Optional build macro LOCTAG_TRIG_FILTER_EN adds a 2-flop synchroniser and a
// 4-clock stability filter on trig.
module loctag_sequencer
    import loctag_pkg::*;
#(
    parameter int CLK_PER_US  = 50,
    parameter int PAYLOAD_LEN = 8,
    parameter int RSS_W       = 8,
    parameter int T_B_START   = 3,
    parameter int T_B_INFO    = 141,
    parameter int T_B_MOD     = 320,
    parameter int T_B_TAIL    = 32,
    parameter int T_N_START   = 2,
    parameter int T_N_INFO    = 64,
    parameter int T_N_MOD     = 128,
    parameter int T_N_TAIL    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trig,
    input  logic                   force_fs,
    input  logic [1:0]             mode,
    input  logic [PAYLOAD_LEN-1:0] payload,
    input  logic                   adc_eoc,
    input  logic [RSS_W-1:0]       adc_data,
    output logic                   adc_soc,
    output logic                   fs_en,
    output logic                   mod_bit,
    output logic [RSS_W-1:0]       rss,
    output logic                   rss_valid,
    output logic                   us_tick,
    output logic [2:0]             phase,
    output logic                   done
);

    localparam logic [DUR_W-1:0] B_START = min_one(T_B_START);
    localparam logic [DUR_W-1:0] B_INFO  = min_one(T_B_INFO);
    localparam logic [DUR_W-1:0] B_MOD   = min_one(T_B_MOD);
    localparam logic [DUR_W-1:0] B_TAIL  = DUR_W'(T_B_TAIL);
    localparam logic [DUR_W-1:0] N_START = min_one(T_N_START);
    localparam logic [DUR_W-1:0] N_INFO  = min_one(T_N_INFO);
    localparam logic [DUR_W-1:0] N_MOD   = min_one(T_N_MOD);
    localparam logic [DUR_W-1:0] N_TAIL  = DUR_W'(T_N_TAIL);

    state_t                   state;
    state_t                   next_state;
    logic [1:0]               mode_reg;
    logic [PAYLOAD_LEN-1:0]   shift_reg;
    logic [DUR_W-1:0]         us_count;
    logic [DUR_W-1:0]         cur_dur;
    logic [DUR_W-1:0]         tail_dur;
    logic                     trig_eff;
    logic                     state_entry;
    logic                     phase_end;
    logic                     is_b;

`ifdef LOCTAG_TRIG_FILTER_EN
    logic       trig_s1;
    logic       trig_s2;
    logic       trig_filt;
    logic [1:0] stable_cnt;

    // Synchronise trig, then accept a new level only after 4 stable clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_s1    <= 1'b0;
            trig_s2    <= 1'b0;
            trig_filt  <= 1'b0;
            stable_cnt <= 2'd0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            if (trig_s2 == trig_filt) begin
                stable_cnt <= 2'd0;
            end else if (stable_cnt == 2'd3) begin
                trig_filt  <= trig_s2;
                stable_cnt <= 2'd0;
            end else begin
                stable_cnt <= stable_cnt + 2'd1;
            end
        end
    end

    assign trig_eff = trig_filt;
`else
    assign trig_eff = trig;
`endif

    assign is_b        = (mode_reg == MODE_B);
    assign tail_dur    = is_b ? B_TAIL : N_TAIL;
    assign state_entry = (next_state != state);
    assign phase_end   = us_tick && (us_count == cur_dur - 1'b1);
    assign phase       = state;

    loctag_us_tick #(
        .CLK_PER_US (CLK_PER_US),
        .CNT_W      (DUR_W)
    ) u_us_tick (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_entry),
        .us_tick (us_tick),
        .count   (us_count)
    );

    // Length in microseconds of the phase currently being timed.
    always_comb begin
        cur_dur = DUR_W'(1);
        case (state)
            START:   cur_dur = is_b ? B_START : N_START;
            INFO:    cur_dur = is_b ? B_INFO  : N_INFO;
            MOD:     cur_dur = is_b ? B_MOD   : N_MOD;
            TAIL:    cur_dur = tail_dur;
            default: cur_dur = DUR_W'(1);
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection (force, then abort, then timed flow) and state-decoded outputs.
    always_comb begin
        next_state = state;
        fs_en      = 1'b0;
        mod_bit    = 1'b0;
        fs_en      = (state != IDLE);
        if (state == MOD) begin
            mod_bit = shift_reg[PAYLOAD_LEN-1];
        end
        if (force_fs) begin
            next_state = FORCE_FS;
        end else if (!trig_eff) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     if (mode == MODE_B || mode == MODE_N) next_state = START;
                FORCE_FS: next_state = IDLE;
                START:    if (phase_end) next_state = INFO;
                INFO:     if (phase_end) next_state = MOD;
                MOD:      if (phase_end) next_state = (tail_dur == '0) ? WAIT_END : TAIL;
                TAIL:     if (phase_end) next_state = WAIT_END;
                WAIT_END: next_state = WAIT_END;
                default:  next_state = IDLE;
            endcase
        end
    end

    // Per-packet datapath: mode capture, payload shifting, RSS latch and entry pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg  <= 2'b00;
            shift_reg <= '0;
            rss       <= {RSS_W{RSS_RESET_BIT}};
            rss_valid <= 1'b0;
            adc_soc   <= 1'b0;
            done      <= 1'b0;
        end else begin
            adc_soc <= state_entry && (next_state == START);
            done    <= state_entry && (next_state == WAIT_END);
            if (state_entry && next_state == START) begin
                mode_reg  <= mode;
                shift_reg <= payload;
                rss       <= {RSS_W{RSS_RESET_BIT}};
                rss_valid <= 1'b0;
            end else begin
                if (state == MOD && us_tick) begin
                    shift_reg <= shift_reg << 1;
                end
                if (state == INFO && adc_eoc && !rss_valid) begin
                    rss       <= adc_data;
                    rss_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_loctag_sequencer.sv
// Self-checking bench for loctag_sequencer: directed scenarios plus randomized
// stimulus, all compared against a cycle-count based reference model.
module tb_loctag_sequencer;

    localparam int CLK_US   = 4;
    localparam int PL       = 8;
    localparam int TB_START = 2;
    localparam int TB_INFO  = 3;
    localparam int TB_MOD   = 8;
    localparam int TB_TAIL  = 2;
    localparam int TN_START = 1;
    localparam int TN_INFO  = 2;
    localparam int TN_MOD   = 10;
    localparam int TN_TAIL  = 0;

    localparam int P_IDLE  = 0;
    localparam int P_FORCE = 1;
    localparam int P_START = 2;
    localparam int P_INFO  = 3;
    localparam int P_MOD   = 4;
    localparam int P_TAIL  = 5;
    localparam int P_WAIT  = 6;

    logic       clk;
    logic       reset;
    logic       trig;
    logic       force_fs;
    logic [1:0] mode;
    logic [7:0] payload;
    logic       adc_eoc;
    logic [7:0] adc_data;
    logic       adc_soc;
    logic       fs_en;
    logic       mod_bit;
    logic [7:0] rss;
    logic       rss_valid;
    logic       us_tick;
    logic [2:0] phase;
    logic       done;

    logic [15:0] dut_vec;

    int vectors;
    int miscompares;

    int         m_phase;
    int         m_elapsed;
    logic [1:0] m_mode;
    logic [7:0] m_payload;
    logic [7:0] m_rss;
    bit         m_rss_valid;
    bit         m_soc;
    bit         m_done;

    loctag_sequencer #(
        .CLK_PER_US  (CLK_US),
        .PAYLOAD_LEN (PL),
        .RSS_W       (8),
        .T_B_START   (TB_START),
        .T_B_INFO    (TB_INFO),
        .T_B_MOD     (TB_MOD),
        .T_B_TAIL    (TB_TAIL),
        .T_N_START   (TN_START),
        .T_N_INFO    (TN_INFO),
        .T_N_MOD     (TN_MOD),
        .T_N_TAIL    (TN_TAIL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .force_fs  (force_fs),
        .mode      (mode),
        .payload   (payload),
        .adc_eoc   (adc_eoc),
        .adc_data  (adc_data),
        .adc_soc   (adc_soc),
        .fs_en     (fs_en),
        .mod_bit   (mod_bit),
        .rss       (rss),
        .rss_valid (rss_valid),
        .us_tick   (us_tick),
        .phase     (phase),
        .done      (done)
    );

    assign dut_vec = {phase, fs_en, mod_bit, adc_soc, done, us_tick, rss_valid, rss};

    always #5 clk = ~clk;

    function automatic int phase_len(input int p);
        int d;
        bit b;
        b = (m_mode == 2'b10);
        d = 0;
        case (p)
            P_START: begin d = b ? TB_START : TN_START; if (d == 0) d = 1; end
            P_INFO:  begin d = b ? TB_INFO  : TN_INFO;  if (d == 0) d = 1; end
            P_MOD:   begin d = b ? TB_MOD   : TN_MOD;   if (d == 0) d = 1; end
            P_TAIL:  d = b ? TB_TAIL : TN_TAIL;
            default: d = 0;
        endcase
        return d * CLK_US;
    endfunction

    function automatic logic [15:0] exp_vec();
        logic mb;
        int   k;
        mb = 1'b0;
        if (m_phase == P_MOD) begin
            k = m_elapsed / CLK_US;
            if (k < PL) mb = m_payload[PL-1-k];
        end
        return {3'(m_phase), (m_phase != P_IDLE), mb, m_soc, m_done,
                ((m_elapsed % CLK_US) == CLK_US - 1), m_rss_valid, m_rss};
    endfunction

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_elapsed   = 0;
        m_mode      = 2'b00;
        m_payload   = 8'h00;
        m_rss       = 8'hFF;
        m_rss_valid = 1'b0;
        m_soc       = 1'b0;
        m_done      = 1'b0;
    endtask

    task automatic model_update();
        int nxt;
        nxt = m_phase;
        if (force_fs) begin
            nxt = P_FORCE;
        end else if (!trig) begin
            nxt = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE:  if (mode == 2'b10 || mode == 2'b01) nxt = P_START;
                P_FORCE: nxt = P_IDLE;
                P_START, P_INFO, P_MOD, P_TAIL: begin
                    if (m_elapsed == phase_len(m_phase) - 1) begin
                        nxt = m_phase + 1;
                        if (nxt == P_TAIL && phase_len(P_TAIL) == 0) nxt = P_WAIT;
                    end
                end
                default: nxt = m_phase;
            endcase
        end
        if (m_phase == P_INFO && adc_eoc && !m_rss_valid) begin
            m_rss       = adc_data;
            m_rss_valid = 1'b1;
        end
        m_soc  = (nxt == P_START && m_phase != P_START);
        m_done = (nxt == P_WAIT && m_phase != P_WAIT);
        if (m_soc) begin
            m_mode      = mode;
            m_payload   = payload;
            m_rss       = 8'hFF;
            m_rss_valid = 1'b0;
        end
        m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL idle_after_reset t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_b_sequence();
        int soc_k;
        int done_k;
        int rel;
        logic [7:0] bits;
        soc_k   = -1;
        done_k  = -1;
        bits    = 8'h00;
        payload = 8'hA5;
        mode    = 2'b10;
        trig    = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL b_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
            if (m_soc && soc_k < 0) soc_k = cyc;
            if (done && done_k < 0) done_k = cyc;
            if (soc_k >= 0) begin
                rel = cyc - soc_k;
                if (rel >= 21 && rel <= 49 && ((rel - 21) % 4) == 0) bits = {bits[6:0], mod_bit};
            end
        end
        vectors++;
        if (done_k < 0 || (done_k - soc_k) !== 60) begin
            miscompares++;
            $display("[TB] FAIL done_latency got=%0d exp=60", done_k < 0 ? -1 : done_k - soc_k);
        end
        vectors++;
        if (bits !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL mod_pattern got=%h exp=a5", bits);
        end
        trig = 1'b0;
        step();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL b_seq_end t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
        end
    endtask

    task automatic test_rss_capture();
        int k;
        k       = -1;
        mode    = 2'b10;
        payload = 8'($urandom);
        trig    = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL rss_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
            if (m_soc) k = 0;
            else if (k >= 0) k++;
            adc_eoc  = (k == 9 || k == 13);
            adc_data = (k == 9) ? 8'h3C : (k == 13) ? 8'h11 : 8'($urandom);
        end
        vectors++;
        if ({rss_valid, rss} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("[TB] FAIL rss_latch got=%b/%h exp=1/3c", rss_valid, rss);
        end
        trig    = 1'b0;
        adc_eoc = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int k;
        k       = -1;
        mode    = 2'b10;
        payload = 8'($urandom);
        trig    = 1'b1;
        for (int cyc = 0; cyc < 60 && k < 30; cyc++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL abort_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
            if (m_soc) k = 0;
            else if (k >= 0) k++;
            adc_eoc  = (k == 10);
            adc_data = 8'h5A;
        end
        adc_eoc = 1'b0;
        trig    = 1'b0;
        step();
        vectors++;
        if ({phase, mod_bit, done, fs_en} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL abort_idle got=%0d/%b/%b/%b exp=0/0/0/0", phase, mod_bit, done, fs_en);
        end
        trig = 1'b1;
        step();
        vectors++;
        if ({phase, rss, rss_valid} !== {3'd2, 8'hFF, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL restart_rss got=%0d/%h/%b exp=2/ff/0", phase, rss, rss_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL restart_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
        trig = 1'b0;
        step();
    endtask

    task automatic test_mode();
        int k;
        bit saw_tail;
        bit mod_to_wait;
        logic [2:0] prev;
        mode = 2'b11;
        trig = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL mode11_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (phase !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL mode11_idle got=%0d exp=0", phase);
        end
        trig = 1'b0;
        step();
        k           = -1;
        saw_tail    = 1'b0;
        mod_to_wait = 1'b0;
        prev        = 3'd0;
        mode        = 2'b01;
        payload     = 8'($urandom);
        trig        = 1'b1;
        for (int cyc = 0; cyc < 100 && !mod_to_wait; cyc++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL n_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
            if (m_soc) k = 0;
            else if (k >= 0) k++;
            if (k == 6) mode = 2'b10;
            if (phase == 3'd5) saw_tail = 1'b1;
            if (prev == 3'd4 && phase == 3'd6) mod_to_wait = 1'b1;
            prev = phase;
        end
        vectors++;
        if ({saw_tail, mod_to_wait} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL n_mode_kept got tail=%b mod_to_wait=%b exp tail=0 mod_to_wait=1", saw_tail, mod_to_wait);
        end
        trig = 1'b0;
        mode = 2'b00;
        step();
    endtask

    task automatic test_force_fs();
        int k;
        int at;
        for (int r = 0; r < 3; r++) begin
            k       = -1;
            at      = int'($urandom_range(1, 60));
            mode    = 2'b10;
            payload = 8'($urandom);
            trig    = 1'b1;
            for (int cyc = 0; cyc < 80 && k < at; cyc++) begin
                step();
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    miscompares++;
                    $display("[TB] FAIL force_seq t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
                end
                if (m_soc) k = 0;
                else if (k >= 0) k++;
            end
            force_fs = 1'b1;
            step();
            vectors++;
            if ({phase, fs_en, mod_bit} !== {3'd1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL force_enter got=%0d/%b/%b exp=1/1/0", phase, fs_en, mod_bit);
            end
            for (int i = 0; i < 3; i++) begin
                trig = 1'($urandom_range(0, 1));
                step();
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    miscompares++;
                    $display("[TB] FAIL force_hold t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
                end
            end
            trig     = 1'b1;
            force_fs = 1'b0;
            step();
            vectors++;
            if ({phase, fs_en} !== {3'd0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL force_release got=%0d/%b exp=0/0", phase, fs_en);
            end
            trig = 1'b0;
            step();
        end
    endtask

    task automatic test_async_reset();
        int k;
        k       = -1;
        mode    = 2'b10;
        payload = 8'($urandom);
        trig    = 1'b1;
        for (int cyc = 0; cyc < 60 && k < 25; cyc++) begin
            step();
            if (m_soc) k = 0;
            else if (k >= 0) k++;
            adc_eoc  = (k == 10);
            adc_data = 8'h42;
        end
        adc_eoc = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL async_reset t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
        end
        vectors++;
        if ({phase, rss, rss_valid, fs_en, mod_bit} !== {3'd0, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid got=%0d/%h/%b/%b/%b exp=0/ff/0/0/0", phase, rss, rss_valid, fs_en, mod_bit);
        end
        reset = 1'b0;
        trig  = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            trig     = ($urandom_range(0, 999) >= 5);
            force_fs = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            payload  = 8'($urandom);
            adc_eoc  = ($urandom_range(0, 9) == 0);
            adc_data = 8'($urandom);
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
    endtask

`ifdef LOCTAG_TRIG_FILTER_EN
    task automatic test_trig_filter();
        bit moved;
        int cnt;
        moved = 1'b0;
        mode  = 2'b10;
        trig  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (phase !== 3'd0) moved = 1'b1;
        end
        trig = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (phase !== 3'd0) moved = 1'b1;
        end
        vectors++;
        if (moved) begin
            miscompares++;
            $display("[TB] FAIL filter_glitch got=moved exp=idle");
        end
        trig = 1'b1;
        cnt  = 0;
        while (cnt < 20 && phase !== 3'd2) begin
            step();
            cnt++;
        end
        vectors++;
        if (cnt !== 7) begin
            miscompares++;
            $display("[TB] FAIL filter_start got=%0d exp=7", cnt);
        end
        trig = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask
`endif

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        trig        = 1'b0;
        force_fs    = 1'b0;
        mode        = 2'b00;
        payload     = 8'h00;
        adc_eoc     = 1'b0;
        adc_data    = 8'h00;
        vectors     = 0;
        miscompares = 0;
        test_reset();
`ifdef LOCTAG_TRIG_FILTER_EN
        test_trig_filter();
`else
        test_b_sequence();
        test_rss_capture();
        test_abort();
        test_mode();
        test_force_fs();
        test_async_reset();
        test_random();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
